// File: rtl/bldcm_commutation_sequencer.sv
// bldcm_commutation_sequencer: six-step BLDC commutation with step timing and dead time
module bldcm_commutation_sequencer #(
  parameter logic [7:0] pDeadCycles = 8'd2
) (
  input  logic        iClock,
  input  logic        iReset_n,
  input  logic [31:0] iDiv,
  input  logic        iStop,
  input  logic        iReverse,
  output logic [2:0]  oPhase,
  output logic [2:0]  oHighSide,
  output logic [2:0]  oLowSide,
  output logic        oStepPulse,
  output logic        oRunning
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, divl_q, divl_d, div_sat;
  logic [7:0]  dead_q, dead_d;
  logic [2:0]  phase_q, phase_d, hi_q, hi_d, lo_q, lo_d;
  logic        pulse_q, pulse_d, run_q, step, gates_on;
  assign oPhase     = phase_q;
  assign oHighSide  = hi_q;
  assign oLowSide   = lo_q;
  assign oStepPulse = pulse_q;
  assign oRunning   = run_q;
  // next state: stop beats step; gates come from next-state phase and dead counter so they move with oPhase
  always_comb begin
    div_sat  = (iDiv == 32'd0) ? 32'd1 : iDiv;
    step     = (state_q == RUN) && !iStop && (cnt_q == divl_q - 32'd1);
    state_d  = state_q;
    cnt_d    = cnt_q;
    divl_d   = divl_q;
    dead_d   = dead_q;
    phase_d  = phase_q;
    pulse_d  = 1'b0;
    if (state_q == IDLE) begin
      if (!iStop) begin
        state_d = RUN;
        cnt_d   = 32'd0;
        divl_d  = div_sat;
        dead_d  = pDeadCycles;
      end
    end else if (iStop) begin
      state_d = IDLE;
      cnt_d   = 32'd0;
      dead_d  = 8'd0;
    end else if (step) begin
      cnt_d   = 32'd0;
      divl_d  = div_sat;
      dead_d  = pDeadCycles;
      pulse_d = 1'b1;
      phase_d = iReverse ? ((phase_q == 3'd0) ? 3'd5 : phase_q - 3'd1)
                         : ((phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1);
    end else begin
      cnt_d  = cnt_q + 32'd1;
      dead_d = (dead_q != 8'd0) ? dead_q - 8'd1 : 8'd0;
    end
    gates_on = (state_d == RUN) && (dead_d == 8'd0);
    hi_d = !gates_on ? 3'b000 :
           (phase_d <= 3'd1) ? 3'b001 :
           (phase_d <= 3'd3) ? 3'b010 : 3'b100;
    lo_d = !gates_on ? 3'b000 :
           (phase_d == 3'd0 || phase_d == 3'd5) ? 3'b010 :
           (phase_d == 3'd1 || phase_d == 3'd2) ? 3'b100 : 3'b001;
  end
  // state and registered outputs
  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      divl_q  <= 32'd1;
      dead_q  <= 8'd0;
      phase_q <= 3'd0;
      hi_q    <= 3'b000;
      lo_q    <= 3'b000;
      pulse_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      divl_q  <= divl_d;
      dead_q  <= dead_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pulse_q <= pulse_d;
      run_q   <= (state_d == RUN);
    end
  end
endmodule

// File: tb/tb_bldcm_commutation_sequencer.sv
// tb_bldcm_commutation_sequencer: vector table driven through a scoreboard, two dead-time variants
module tb_bldcm_commutation_sequencer;
  logic        iClock, iReset_n, iStop, iReverse;
  logic [31:0] iDiv;
  logic [2:0]  p1, h1, l1, p0, h0, l0;
  logic        s1, r1, s0, r0;
  int          n_cmp = 0, n_bad = 0;
  typedef struct {
    logic        rst_n, stop, rev;
    logic [31:0] div;
    logic [2:0]  ph;
    logic        on, pulse, run;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  bldcm_commutation_sequencer #(.pDeadCycles(8'd1)) dut1 (
    .iClock(iClock), .iReset_n(iReset_n), .iDiv(iDiv), .iStop(iStop), .iReverse(iReverse),
    .oPhase(p1), .oHighSide(h1), .oLowSide(l1), .oStepPulse(s1), .oRunning(r1));
  bldcm_commutation_sequencer #(.pDeadCycles(8'd0)) dut0 (
    .iClock(iClock), .iReset_n(iReset_n), .iDiv(iDiv), .iStop(iStop), .iReverse(iReverse),
    .oPhase(p0), .oHighSide(h0), .oLowSide(l0), .oStepPulse(s0), .oRunning(r0));
  initial iClock = 1'b0;
  always #5 iClock = ~iClock;
  function automatic logic [5:0] tbl(input logic [2:0] p);
    return p == 3'd0 ? 6'b001_010 : p == 3'd1 ? 6'b001_100 : p == 3'd2 ? 6'b010_100 :
           p == 3'd3 ? 6'b010_001 : p == 3'd4 ? 6'b100_001 : 6'b100_010;
  endfunction
  function automatic void add(input logic r, s, v, input logic [31:0] d, input logic [2:0] p,
                              input logic o, pu, ru);
    vec_t x;
    x.rst_n = r; x.stop = s; x.rev = v; x.div = d; x.ph = p; x.on = o; x.pulse = pu; x.run = ru;
    vecs.push_back(x);
  endfunction
  task automatic chk(input string name, input int idx, input logic [10:0] got, input logic [10:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got {ph,hi,lo,pulse,run}=%b required %b", name, idx, got, exp);
    end
  endtask
  initial begin
    repeat (3) add(0, 1, 0, 4, 0, 0, 0, 0);
    repeat (20) add(1, 1, 0, 4, 0, 0, 0, 0);
    add(1, 0, 0, 4, 0, 0, 0, 1);
    repeat (3) add(1, 0, 0, 4, 0, 1, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      add(1, 0, 0, 4, 3'(k % 6), 0, 1, 1);
      repeat (3) add(1, 0, 0, 4, 3'(k % 6), 1, 0, 1);
    end
    for (int k = 5; k >= 3; k--) begin
      add(1, 0, 1, 3, 3'(k), 0, 1, 1);
      repeat (2) add(1, 0, 1, 3, 3'(k), 1, 0, 1);
    end
    add(1, 0, 1, 3, 2, 0, 1, 1);
    add(1, 0, 1, 3, 2, 1, 0, 1);
    add(1, 1, 1, 3, 2, 0, 0, 0);
    repeat (3) add(1, 1, 1, 5, 2, 0, 0, 0);
    add(1, 0, 1, 3, 2, 0, 0, 1);
    repeat (2) add(1, 0, 1, 3, 2, 1, 0, 1);
    add(1, 0, 1, 3, 1, 0, 1, 1);
    repeat (2) add(1, 0, 1, 3, 1, 1, 0, 1);
    add(1, 1, 1, 3, 1, 0, 0, 0);
    add(1, 0, 0, 8, 1, 0, 0, 1);
    add(1, 0, 0, 8, 1, 1, 0, 1);
    repeat (6) add(1, 0, 0, 2, 1, 1, 0, 1);
    for (int k = 2; k <= 4; k++) begin
      add(1, 0, 0, 2, 3'(k), 0, 1, 1);
      add(1, 0, 0, 2, 3'(k), 1, 0, 1);
    end
    for (int k = 5; k <= 12; k++) add(1, 0, 0, 0, 3'(k % 6), 0, 1, 1);
    repeat (2) add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 4, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v, e;
      v = vecs[i];
      iReset_n = v.rst_n; iStop = v.stop; iReverse = v.rev; iDiv = v.div;
      sb.push_back(v);
      @(posedge iClock);
      #1;
      e = sb.pop_front();
      chk("dead1", i, {p1, h1, l1, s1, r1}, {e.ph, e.on ? tbl(e.ph) : 6'b0, e.pulse, e.run});
      chk("dead0", i, {p0, h0, l0, s0, r0}, {e.ph, e.run ? tbl(e.ph) : 6'b0, e.pulse, e.run});
      chk("overlap1", i, {8'b0, h1 & l1}, 11'b0);
      chk("overlap0", i, {8'b0, h0 & l0}, 11'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
